// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port between NUM_REQ
// valid/ready producers, with bursts of up to MAX_BURST beats per grant.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    input  logic                          fifo_full
);

    localparam int unsigned    IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned    CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_REQ  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    int unsigned             cand;
    logic                    busy;
    logic                    own_valid;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester after the last owner, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        cand       = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last_q) + off) % NUM_REQ;
            if (!pick_found && req_valid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign own_valid = req_valid[owner_q];
    assign xfer      = busy && own_valid && !fifo_full;

    // Next-state: arbitration in IDLE, burst counting and release in BUSY
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_BUSY;
                    owner_d = pick_idx;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if ((xfer && (cnt_q == LAST_BEAT)) || !own_valid) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_REQ;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write port is driven straight from the owner's handshake
    assign grant       = grant_q;
    assign req_ready   = (busy && !fifo_full) ? grant_q : '0;
    assign fifo_wr     = xfer;
    assign fifo_w_data = busy ? data_arr[owner_q] : '0;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(grant_q));
    a_no_wr_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(fifo_wr && fifo_full));
    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
        cnt_q <= LAST_BEAT);
    a_grant_matches_state: assert property (@(posedge clk) disable iff (!reset_n)
        busy == (grant_q != '0));

endmodule
